// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared types and helpers for the APB slave bridge.
//   state_t            : bridge FSM states
//   timeout_cnt_width  : bit width needed to count up to a timeout limit
// -----------------------------------------------------------------------------
package apb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_RD,
    RESP,
    ERR
  } state_t;

  // The counter has to hold the value timeout_cycles itself (it saturates
  // there), so it needs clog2(n+1) bits; never narrower than one bit so a
  // disabled timeout (0) still elaborates a legal vector.
  function automatic int timeout_cnt_width(input int timeout_cycles);
    if (timeout_cycles <= 1) return 1;
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// -----------------------------------------------------------------------------
// apb_timeout_cnt
// Saturating cycle counter used to bound how long the bridge waits on the
// back end.
//   i_clk  : clock, rising edge
//   i_rst  : asynchronous active-high reset, clears the count
//   i_clr  : synchronous clear (wins over i_en)
//   i_en   : count this cycle
//   o_tc   : terminal count; high during the LIMIT-th enabled cycle after a
//            clear, i.e. the count reaches LIMIT at the end of this cycle.
//            Always 0 when LIMIT is 0 (timeout disabled).
// -----------------------------------------------------------------------------
module apb_timeout_cnt #(
  parameter int LIMIT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  import apb_pkg::*;

  localparam int           W      = timeout_cnt_width(LIMIT);
  localparam logic [W-1:0] SAT_W  = W'(LIMIT);
  localparam logic [W-1:0] LAST_W = W'(LIMIT - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != SAT_W)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Combinational so the FSM can leave on the same edge the limit is hit.
  assign o_tc = (LIMIT != 0) && i_en && !i_clr && (r_cnt == LAST_W);

endmodule

// File: rtl/apb_slave_bridge.sv
// -----------------------------------------------------------------------------
// apb_slave_bridge
// APB slave that turns each decoded APB transfer into a single valid/ready
// request on a simple back-end port, with a posted-write / waited-read
// response and a back-end timeout.
//   i_clk_apb, i_rst_apb          : clock, async active-high reset
//   i_psel/i_penable/i_pwrite     : APB control
//   i_paddr/i_pwdata/i_pstrb      : APB address, write data, byte strobes
//   o_prdata/o_pready/o_pslverr   : APB response (all registered)
//   o_valid/i_ready               : back-end request handshake
//   o_addr/o_rd0_wr1              : request offset (paddr - BASE_ADDR), dir
//   o_wr_data/o_wr_strb           : request write data and strobes
//   i_rd_valid/i_rd_data          : back-end read return
// -----------------------------------------------------------------------------
module apb_slave_bridge #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    ADDR_SPAN      = 4096,
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input  logic                    i_clk_apb,
  input  logic                    i_rst_apb,
  input  logic                    i_psel,
  input  logic                    i_penable,
  input  logic                    i_pwrite,
  input  logic [ADDR_WIDTH-1:0]   i_paddr,
  input  logic [DATA_WIDTH-1:0]   i_pwdata,
  input  logic [DATA_WIDTH/8-1:0] i_pstrb,
  output logic [DATA_WIDTH-1:0]   o_prdata,
  output logic                    o_pready,
  output logic                    o_pslverr,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [ADDR_WIDTH-1:0]   o_addr,
  output logic                    o_rd0_wr1,
  output logic [DATA_WIDTH-1:0]   o_wr_data,
  output logic [DATA_WIDTH/8-1:0] o_wr_strb,
  input  logic                    i_rd_valid,
  input  logic [DATA_WIDTH-1:0]   i_rd_data
);
  import apb_pkg::*;

  localparam int                    STRB_WIDTH = DATA_WIDTH / 8;
  localparam int                    AW1        = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_WIDTH - 1);
  localparam logic [AW1-1:0]        SPAN_EXT   = AW1'(ADDR_SPAN);

  state_t                  r_state;
  logic [DATA_WIDTH-1:0]   r_prdata;
  logic                    r_pready;
  logic                    r_pslverr;
  logic                    r_valid;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_rd0_wr1;
  logic [DATA_WIDTH-1:0]   r_wr_data;
  logic [STRB_WIDTH-1:0]   r_wr_strb;

  logic [ADDR_WIDTH-1:0]   w_offset;
  logic                    w_in_window;
  logic                    w_aligned;
  logic                    w_hit;
  logic                    w_setup;
  logic                    w_cnt_clr;
  logic                    w_cnt_en;
  logic                    w_timeout;

  // Decode straight from the setup-phase inputs: these are exactly the values
  // latched on the same edge, so the decision needs no extra cycle.
  assign w_setup     = i_psel && !i_penable;
  assign w_offset    = i_paddr - BASE_ADDR;
  // Offset form keeps the upper bound correct even if BASE_ADDR + ADDR_SPAN
  // would wrap the address space.
  assign w_in_window = (i_paddr >= BASE_ADDR) && ({1'b0, w_offset} < SPAN_EXT);
  assign w_aligned   = (i_paddr & ALIGN_MASK) == '0;
  assign w_hit       = w_in_window && w_aligned;

  // Held clear while idle, so the count always starts at zero on entering REQ
  // and keeps running through WAIT_RD: the limit covers the whole back-end wait.
  assign w_cnt_clr = (r_state == IDLE);
  assign w_cnt_en  = (r_state == REQ) || (r_state == WAIT_RD);

  apb_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .i_clk (i_clk_apb),
    .i_rst (i_rst_apb),
    .i_clr (w_cnt_clr),
    .i_en  (w_cnt_en),
    .o_tc  (w_timeout)
  );

  always_ff @(posedge i_clk_apb or posedge i_rst_apb) begin
    if (i_rst_apb) begin
      r_state   <= IDLE;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_valid   <= 1'b0;
      r_addr    <= '0;
      r_rd0_wr1 <= 1'b0;
      r_wr_data <= '0;
      r_wr_strb <= '0;
    end else begin
      // NOTE: response outputs are one-cycle pulses; defaulting them low here
      // with non-blocking assignments means only the branch that enters
      // RESP/ERR has to raise them, and no path can leave a stale value.
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;

      unique case (r_state)
        IDLE: begin
          if (w_setup) begin
            r_addr    <= w_offset;
            r_rd0_wr1 <= i_pwrite;
            r_wr_data <= i_pwdata;
            r_wr_strb <= i_pstrb;
            if (w_hit) begin
              r_state <= REQ;
              r_valid <= 1'b1;
            end else begin
              r_state   <= ERR;
              r_pready  <= 1'b1;
              r_pslverr <= 1'b1;
            end
          end
        end

        REQ: begin
          if (!i_psel) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end else if (i_ready) begin
            // Handshake is checked before the timeout so a completion landing
            // on the terminal cycle is not reported as an error.
            r_valid <= 1'b0;
            if (r_rd0_wr1) begin
              r_state  <= RESP;
              r_pready <= 1'b1;
            end else begin
              r_state <= WAIT_RD;
            end
          end else if (w_timeout) begin
            r_valid   <= 1'b0;
            r_state   <= RESP;
            r_pready  <= 1'b1;
            r_pslverr <= 1'b1;
          end
        end

        WAIT_RD: begin
          if (!i_psel) begin
            r_state <= IDLE;
          end else if (i_rd_valid) begin
            r_state  <= RESP;
            r_pready <= 1'b1;
            r_prdata <= i_rd_data;
          end else if (w_timeout) begin
            r_state   <= RESP;
            r_pready  <= 1'b1;
            r_pslverr <= 1'b1;
          end
        end

        RESP, ERR: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_prdata  = r_prdata;
  assign o_pready  = r_pready;
  assign o_pslverr = r_pslverr;
  assign o_valid   = r_valid;
  assign o_addr    = r_addr;
  assign o_rd0_wr1 = r_rd0_wr1;
  assign o_wr_data = r_wr_data;
  assign o_wr_strb = r_wr_strb;

endmodule

// File: tb/tb_apb_slave_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_bridge
// Directed APB transfers against apb_slave_bridge with default parameters
// (32-bit, BASE_ADDR 0, 4 KiB window, 16-cycle timeout). The driver pushes
// hand-computed expected requests/responses; a negedge monitor pops and
// compares whenever the DUT handshakes a request or raises o_pready.
// -----------------------------------------------------------------------------
module tb_apb_slave_bridge;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
    logic [3:0]  strb;
  } req_t;

  typedef struct {
    int          cyc;
    logic [31:0] prdata;
    logic        err;
    int          vrun;
  } rsp_t;

  logic        clk;
  logic        rst;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic        rd0_wr1;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        rd_valid;
  logic [31:0] rd_data;

  int   cyc;
  int   n_tests;
  int   n_fail;
  int   vrun;
  int   last_run;
  req_t req_q[$];
  rsp_t rsp_q[$];

  apb_slave_bridge dut (
    .i_clk_apb (clk),
    .i_rst_apb (rst),
    .i_psel    (psel),
    .i_penable (penable),
    .i_pwrite  (pwrite),
    .i_paddr   (paddr),
    .i_pwdata  (pwdata),
    .i_pstrb   (pstrb),
    .o_prdata  (prdata),
    .o_pready  (pready),
    .o_pslverr (pslverr),
    .o_valid   (valid),
    .i_ready   (ready),
    .o_addr    (addr),
    .o_rd0_wr1 (rd0_wr1),
    .o_wr_data (wr_data),
    .o_wr_strb (wr_strb),
    .i_rd_valid(rd_valid),
    .i_rd_data (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_prdata"},  prdata,  0);
    check({tag, "_pready"},  pready,  0);
    check({tag, "_pslverr"}, pslverr, 0);
    check({tag, "_valid"},   valid,   0);
    check({tag, "_addr"},    addr,    0);
    check({tag, "_rd0_wr1"}, rd0_wr1, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_wr_strb"}, wr_strb, 0);
  endtask

  // Monitor: scoreboard pops on request handshakes and on o_pready.
  always @(negedge clk) begin
    req_t q;
    rsp_t e;
    if (rst) begin
      vrun     = 0;
      last_run = 0;
    end else begin
      if (psel && !penable) last_run = 0;
      if (valid) vrun++;
      else if (vrun != 0) begin
        last_run = vrun;
        vrun     = 0;
      end

      if (valid && ready) begin
        if (req_q.size() == 0) begin
          check("unexpected_request", {31'b0, valid & ready}, 0);
        end else begin
          q = req_q.pop_front();
          check("req_addr", addr,    q.addr);
          check("req_dir",  rd0_wr1, q.wr);
          check("req_data", wr_data, q.data);
          check("req_strb", wr_strb, q.strb);
        end
      end

      if (pready) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_pready", pready, 0);
        end else begin
          e = rsp_q.pop_front();
          check("rsp_cycle",        cyc,      e.cyc);
          check("rsp_prdata",       prdata,   e.prdata);
          check("rsp_pslverr",      pslverr,  e.err);
          check("rsp_valid_cycles", last_run, e.vrun);
        end
      end else begin
        check("idle_prdata_zero",  prdata,  0);
        check("idle_pslverr_zero", pslverr, 0);
      end
    end
  end

  // One APB transfer. Offsets t are cycles counted from the setup cycle (t=0).
  // ready_at: first t with i_ready=1 (-1 never); rdv_at: t of the single
  // i_rd_valid pulse (-1 none); abort_at: t at which psel drops (-1 none).
  task automatic apb_xfer(
    input logic [31:0] a, input logic wr, input logic [31:0] wd, input logic [3:0] st,
    input int ready_at, input int rdv_at, input logic [31:0] rd,
    input int abort_at, input bit exp_req, input int exp_lat,
    input logic [31:0] exp_prdata, input logic exp_err, input int exp_vrun);
    int   t;
    bit   done;
    req_t q;
    rsp_t e;
    @(posedge clk); #1;
    if (exp_req) begin
      q.addr = a; q.wr = wr; q.data = wd; q.strb = st;
      req_q.push_back(q);
    end
    if (abort_at < 0) begin
      e.cyc = cyc + exp_lat; e.prdata = exp_prdata; e.err = exp_err; e.vrun = exp_vrun;
      rsp_q.push_back(e);
    end
    done = 1'b0;
    t    = 0;
    while (!done) begin
      psel     = (abort_at < 0) || (t < abort_at);
      penable  = psel && (t != 0);
      pwrite   = wr;
      paddr    = a;
      pwdata   = wd;
      pstrb    = st;
      ready    = (ready_at >= 0) && (t >= ready_at);
      rd_valid = (t == rdv_at);
      rd_data  = rd;
      @(negedge clk);
      if (abort_at >= 0) begin
        if (t == abort_at + 1) check("abort_valid_drop", valid, 0);
        if (t == abort_at + 4) done = 1'b1;
      end else if (pready) begin
        done = 1'b1;
      end else if (t >= 40) begin
        check("pready_within_bound", pready, 1);
        done = 1'b1;
      end
      t++;
      @(posedge clk); #1;
    end
    psel = 1'b0; penable = 1'b0; ready = 1'b0; rd_valid = 1'b0;
  endtask

  initial begin
    req_t q;
    n_tests = 0; n_fail = 0;
    rst = 1'b1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    pstrb = 0; ready = 0; rd_valid = 0; rd_data = 0;
    #12;
    check_all_zero("reset");
    @(negedge clk); rst = 1'b0;

    //        addr          wr  wdata         strb  rdy rdv rdata         abt req lat prdata        err vrun
    apb_xfer(32'h0000_0010, 1, 32'hDEADBEEF, 4'hF,  1, -1, 32'h0,        -1, 1,  2, 32'h0,        0,  1);
    apb_xfer(32'h0000_0020, 0, 32'h0,        4'h0,  1,  5, 32'hA5A5_0001,-1, 1,  6, 32'hA5A5_0001,0,  1);
    apb_xfer(32'h0000_1000, 1, 32'h1111_2222,4'hF,  1, -1, 32'h0,        -1, 0,  1, 32'h0,        1,  0);
    apb_xfer(32'h0000_0002, 0, 32'h0,        4'h0,  1, -1, 32'h0,        -1, 0,  1, 32'h0,        1,  0);
    apb_xfer(32'h0000_0FFC, 1, 32'h1234_5678,4'h3,  3, -1, 32'h0,        -1, 1,  4, 32'h0,        0,  3);
    apb_xfer(32'h0000_0040, 1, 32'hCAFE_0000,4'hC, -1, -1, 32'h0,        -1, 0, 17, 32'h0,        1, 16);
    apb_xfer(32'h0000_0044, 1, 32'h0BAD_CAFE,4'hF, 16, -1, 32'h0,        -1, 1, 17, 32'h0,        0, 16);
    apb_xfer(32'h0000_0048, 0, 32'h0,        4'h0,  1, -1, 32'h7777_7777,-1, 1, 17, 32'h0,        1,  1);
    apb_xfer(32'h0000_004C, 0, 32'h0,        4'h0,  1, 16, 32'h0BAD_F00D,-1, 1, 17, 32'h0BAD_F00D,0,  1);
    apb_xfer(32'h0000_0050, 0, 32'h0,        4'h0,  1,  2, 32'h0000_00FF,-1, 1,  3, 32'h0000_00FF,0,  1);
    apb_xfer(32'h0000_0054, 0, 32'h0,        4'h0,  3,  2, 32'h5555_AAAA,-1, 1, 17, 32'h0,        1,  3);
    apb_xfer(32'h0000_0058, 1, 32'h0F0F_0F0F,4'h1, -1, -1, 32'h0,         2, 0,  0, 32'h0,        0,  0);
    apb_xfer(32'h0000_005C, 0, 32'h0,        4'h0,  1,  5, 32'h9999_9999, 3, 1,  0, 32'h0,        0,  0);

    // Reset while waiting for read data: read handshakes at t=1, WAIT_RD from t=2.
    @(posedge clk); #1;
    q.addr = 32'h30; q.wr = 1'b0; q.data = 32'h0; q.strb = 4'h0;
    req_q.push_back(q);
    psel = 1; penable = 0; pwrite = 0; paddr = 32'h30; pwdata = 0; pstrb = 0; ready = 1;
    @(posedge clk); #1; penable = 1;
    @(posedge clk); #1; ready = 0;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1 check_all_zero("mid_reset");
    psel = 0; penable = 0;
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1; rd_valid = 1; rd_data = 32'hFFFF_FFFF;
    @(posedge clk); #1; rd_valid = 0;
    repeat (2) @(posedge clk);
    #1 check_all_zero("after_stale_rd");

    apb_xfer(32'h0000_0060, 1, 32'h0102_0304,4'hF,  1, -1, 32'h0,        -1, 1,  2, 32'h0,        0,  1);

    repeat (5) @(posedge clk);
    check("rsp_queue_empty", rsp_q.size(), 0);
    check("req_queue_empty", req_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
